// File: rtl/if_id_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_id_fetch_queue
//   Decoupling FIFO between instruction fetch (IF) and decode (ID). Each
//   fetched {PCPlus, inst} pair is written into a small circular buffer. The
//   oldest entry is presented to ID. A taken branch (flush) discards every
//   buffered entry, which are all wrong-path at that point.
//
// Ports
//   clk        pipeline clock, rising edge
//   rst        asynchronous active-high reset
//   flush      branchTaken from EXE; empties the queue on the next edge
//   in_valid   fetch presents an instruction
//   in_pc      PCPlus (PC+4) of the fetched instruction
//   in_inst    fetched instruction word
//   in_ready   queue can accept a push (fetch freezes on ~in_ready)
//   out_valid  head entry valid
//   out_pc     head PCPlus, 0 when empty
//   out_inst   head instruction, 0 (NOP bubble) when empty
//   out_ready  ID consumes the head (~hazard freeze)
//   count      number of valid entries, 0..DEPTH
// ---------------------------------------------------------------------------

// One storage slot. It is not reset, because contents are only observed
// while count covers them.
module if_id_fetch_queue_entry (
  input  logic        clk,
  input  logic        i_we,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_inst,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst
);
  logic [31:0] r_pc;
  logic [31:0] r_inst;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_pc   <= i_pc;
      r_inst <= i_inst;
    end
  end

  assign o_pc   = r_pc;
  assign o_inst = r_inst;
endmodule

module if_id_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_inst,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst,
  input  logic             out_ready,
  output logic [PTR_W:0]   count
);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;

  logic             w_push;
  logic             w_pop;
  logic [DEPTH-1:0][31:0] w_ent_pc;
  logic [DEPTH-1:0][31:0] w_ent_inst;

  // Ready/valid come only from the registered count. There is therefore no
  // combinational path from out_ready to in_ready, and none from in_* to out_*.
  assign in_ready  = (r_count != FULL);
  assign out_valid = (r_count != '0);
  assign count     = r_count;

  // Flush dominates: a handshake in the flush cycle belongs to the wrong path.
  assign w_push = in_valid  & in_ready  & ~flush;
  assign w_pop  = out_valid & out_ready & ~flush;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    localparam logic [PTR_W-1:0] IDX = PTR_W'(g);
    if_id_fetch_queue_entry u_ent (
      .clk    (clk),
      .i_we   (w_push && (r_wr_ptr == IDX)),
      .i_pc   (in_pc),
      .i_inst (in_inst),
      .o_pc   (w_ent_pc[g]),
      .o_inst (w_ent_inst[g])
    );
  end

  // When the queue is empty, drive a zero word so that ID sees a NOP bubble.
  assign out_pc   = out_valid ? w_ent_pc[r_rd_ptr]   : 32'h0;
  assign out_inst = out_valid ? w_ent_inst[r_rd_ptr] : 32'h0;

  // The pointers are exactly log2(DEPTH) wide, so the +1 wraps modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_if_id_fetch_queue.sv
module tb_if_id_fetch_queue;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic clk, rst, flush, in_valid, out_ready;
  logic [31:0] in_pc, in_inst;
  logic in_ready, out_valid;
  logic [31:0] out_pc, out_inst;
  logic [PTR_W:0] count;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;
  bit seen_wrong = 0;

  // Reference model: the queue contents in order, each item {pc, inst}.
  logic [63:0] mq[$];

  if_id_fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .out_ready(out_ready), .count(count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model update.
  always @(posedge rst) mq.delete();
  always @(posedge clk) begin
    if (rst || flush) mq.delete();
    else begin
      bit do_push, do_pop;
      do_push = in_valid && (mq.size() != DEPTH);
      do_pop  = out_ready && (mq.size() != 0);
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back({in_pc, in_inst});
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [63:0] head;
      head = (mq.size() != 0) ? mq[0] : 64'h0;
      chk("count",     64'(count),     64'(mq.size()));
      chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      chk("in_ready",  64'(in_ready),  64'(mq.size() != DEPTH));
      chk("out_pc",    64'(out_pc),    64'(head[63:32]));
      chk("out_inst",  64'(out_inst),  64'(head[31:0]));
      if (out_valid && out_inst == 32'h11111111) seen_wrong = 1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins, input logic rdy);
    in_valid = v; in_pc = pc; in_inst = ins; out_ready = rdy;
  endtask

  logic [31:0] drain_exp [4];

  initial begin
    rst = 0; flush = 0; drive(0, 0, 0, 0);
    #1 rst = 1;
    chk_en = 1;
    // Reset then idle.
    repeat (2) begin
      tick();
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd1);
      chk("rst_inst",  64'(out_inst), 64'd0);
    end
    rst = 0;
    tick();

    // Fill with back-pressure.
    drive(1, 32'h4,  32'hE3A01001, 0); tick();
    drive(1, 32'h8,  32'hE3A02002, 0); tick();
    drive(1, 32'hC,  32'hE0813002, 0); tick();
    drive(1, 32'h10, 32'hE2833001, 0); tick();
    drive(1, 32'h14, 32'hDEADBEEF, 0); tick(); tick();
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(in_ready), 64'd0);
    chk("full_inst",  64'(out_inst), 64'hE3A01001);
    chk("full_pc",    64'(out_pc),   64'h4);

    // Drain in push order; the 5th word must not show up.
    drain_exp = '{32'hE3A01001, 32'hE3A02002, 32'hE0813002, 32'hE2833001};
    drive(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", 64'(out_inst), 64'(drain_exp[i]));
      tick();
    end
    chk("drain_empty", 64'(out_valid), 64'd0);
    chk("drain_noextra", 64'(out_inst), 64'd0);

    // Push three more while popping continuously, so the pointers wrap.
    drive(1, 32'h100, 32'hA0000001, 1); tick();
    chk("wrap_h1", 64'(out_inst), 64'hA0000001);
    drive(1, 32'h104, 32'hA0000002, 1); tick();
    chk("wrap_h2", 64'(out_inst), 64'hA0000002);
    drive(1, 32'h108, 32'hA0000003, 1); tick();
    chk("wrap_h3", 64'(out_inst), 64'hA0000003);
    chk("wrap_pc3", 64'(out_pc), 64'h108);
    drive(0, 0, 0, 1); tick();
    chk("wrap_cnt0", 64'(count), 64'd0);
    chk("wrap_v0",   64'(out_valid), 64'd0);

    // Simultaneous push/pop at count=2.
    drive(1, 32'h200, 32'hB0000001, 0); tick();
    drive(1, 32'h204, 32'hB0000002, 0); tick();
    drive(1, 32'h208, 32'hB0000003, 1); tick();
    chk("pp_count", 64'(count), 64'd2);
    chk("pp_head",  64'(out_inst), 64'hB0000002);
    drive(0, 0, 0, 1); tick();
    chk("pp_next",  64'(out_inst), 64'hB0000003);
    tick();
    chk("pp_empty", 64'(count), 64'd0);

    // Flush with a concurrent push.
    drive(1, 32'h300, 32'hC0000001, 0); tick();
    drive(1, 32'h304, 32'hC0000002, 0); tick();
    drive(1, 32'h308, 32'hC0000003, 0); tick();
    chk("fl_pre", 64'(count), 64'd3);
    flush = 1; drive(1, 32'h30C, 32'h11111111, 1); tick();
    flush = 0;
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_ready", 64'(in_ready), 64'd1);
    drive(1, 32'h400, 32'h22222222, 0); tick();
    chk("fl_follow", 64'(out_inst), 64'h22222222);
    chk("fl_fpc",    64'(out_pc),   64'h400);
    drive(0, 0, 0, 1); tick(); tick();
    chk("fl_wrong", 64'(seen_wrong), 64'd0);

    // Async reset mid-stream.
    drive(1, 32'h500, 32'hD0000001, 0); tick();
    drive(1, 32'h504, 32'hD0000002, 0); tick();
    drive(1, 32'h508, 32'hD0000003, 0); tick();
    drive(0, 0, 0, 0);
    chk("ar_pre", 64'(count), 64'd3);
    #1 rst = 1;
    #1;
    chk("ar_count", 64'(count), 64'd0);
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_ready", 64'(in_ready), 64'd1);
    chk("ar_inst",  64'(out_inst), 64'd0);
    tick(); rst = 0; tick();
    drive(1, 32'h600, 32'hE0000001, 0); tick();
    drive(1, 32'h604, 32'hE0000002, 1); tick();
    chk("ar_resume", 64'(out_inst), 64'hE0000002);
    chk("ar_rcount", 64'(count), 64'd1);
    drive(0, 0, 0, 1); tick();

    // Randomized traffic checked by the per-cycle model comparison.
    for (int i = 0; i < 600; i++) begin
      flush = ($urandom_range(0, 19) == 0);
      drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 2) != 0);
      if ($urandom_range(0, 199) == 0) begin
        rst = 1; tick(); rst = 0;
      end else tick();
    end
    drive(0, 0, 0, 1); flush = 0;
    repeat (6) tick();
    chk("final_empty", 64'(count), 64'd0);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
